// File: rtl/alu_pkg.sv
// Shared opcode definitions and limits for the pipelined ALU.
package alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    SEL      = 4'd0,
    INC      = 4'd1,
    DEC      = 4'd2,
    ADD      = 4'd3,
    ADD_C    = 4'd4,
    SUB      = 4'd5,
    SUB_B    = 4'd6,
    AND      = 4'd7,
    OR       = 4'd8,
    XOR      = 4'd9,
    SHIFT_L  = 4'd10,
    SHIFT_R  = 4'd11,
    ROTATE_L = 4'd12,
    ROTATE_R = 4'd13
  } opcode_e;

  // Codes from here upward are not part of the instruction set.
  localparam logic [OPCODE_W-1:0] OP_ILLEGAL_MIN = 4'd14;

  // Deepest pipeline the block supports.
  localparam int STAGES_MAX = 4;

  // True for opcodes outside the defined instruction set.
  function automatic logic is_illegal(input logic [OPCODE_W-1:0] code);
    return (code >= OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-side and result-side handshake bundle of the pipelined ALU.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic                valid_in;
  logic                ready_in;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                cin;
  logic [OPCODE_W-1:0] ctl;
  logic                valid_out;
  logic                ready_out;
  logic [WIDTH-1:0]    alu;
  logic                carry;
  logic                zero;
  logic                overflow;
  logic                err;

  // Operand source plus result consumer.
  modport master (
    output valid_in, a, b, cin, ctl, ready_out,
    input  ready_in, valid_out, alu, carry, zero, overflow, err
  );

  // The ALU pipeline itself.
  modport slave (
    input  valid_in, a, b, cin, ctl, ready_out,
    output ready_in, valid_out, alu, carry, zero, overflow, err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags for one operand set.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                cin,
  input  logic [OPCODE_W-1:0] ctl,
  output logic [WIDTH-1:0]    alu,
  output logic                carry,
  output logic                zero,
  output logic                overflow,
  output logic                err
);

  localparam int MSB = WIDTH - 1;

  opcode_e          op_s;
  logic [WIDTH-1:0] rhs_s;
  logic             cin_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;

  assign op_s = opcode_e'(ctl);

  // INC/DEC reuse the adder/subtractor with a constant one as second operand;
  // only ADD_C and SUB_B let the external carry/borrow in.
  always_comb begin
    rhs_s = b;
    cin_s = 1'b0;
    case (op_s)
      INC, DEC: begin
        rhs_s = {{(WIDTH-1){1'b0}}, 1'b1};
        cin_s = 1'b0;
      end
      ADD_C, SUB_B: begin
        rhs_s = b;
        cin_s = cin;
      end
      default: begin
        rhs_s = b;
        cin_s = 1'b0;
      end
    endcase
  end

  // One extra bit on each side exposes carry-out and borrow directly.
  assign add_s = {1'b0, a} + {1'b0, rhs_s} + {{WIDTH{1'b0}}, cin_s};
  assign sub_s = {1'b0, a} - {1'b0, rhs_s} - {{WIDTH{1'b0}}, cin_s};

  // Signed overflow from the operand and result sign bits.
  assign add_ovf_s = (a[MSB] == rhs_s[MSB]) && (add_s[MSB] != a[MSB]);
  assign sub_ovf_s = (a[MSB] != rhs_s[MSB]) && (sub_s[MSB] != a[MSB]);

  // Opcode decode: select result, carry/borrow/shifted-out bit and flags.
  always_comb begin
    alu      = {WIDTH{1'b0}};
    carry    = 1'b0;
    overflow = 1'b0;
    err      = 1'b0;
    case (op_s)
      SEL: begin
        alu = a;
      end
      INC, ADD, ADD_C: begin
        alu      = add_s[MSB:0];
        carry    = add_s[WIDTH];
        overflow = add_ovf_s;
      end
      DEC, SUB, SUB_B: begin
        alu      = sub_s[MSB:0];
        carry    = sub_s[WIDTH];
        overflow = sub_ovf_s;
      end
      AND: begin
        alu = a & b;
      end
      OR: begin
        alu = a | b;
      end
      XOR: begin
        alu = a ^ b;
      end
      SHIFT_L: begin
        alu   = {a[MSB-1:0], 1'b0};
        carry = a[MSB];
      end
      SHIFT_R: begin
        alu   = {1'b0, a[MSB:1]};
        carry = a[0];
      end
      ROTATE_L: begin
        alu   = {a[MSB-1:0], a[MSB]};
        carry = a[MSB];
      end
      ROTATE_R: begin
        alu   = {a[0], a[MSB:1]};
        carry = a[0];
      end
      default: begin
        // Undefined opcodes complete as a zero result tagged with err.
        alu      = {WIDTH{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
        err      = is_illegal(ctl);
      end
    endcase
  end

  assign zero = (alu == {WIDTH{1'b0}});

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute into stage 1, then delay stages,
// with valid/ready flow control on both sides and collapsing bubbles.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input logic       clk,
  input logic       reset,
  alu_pipe_if.slave bus
);

  // Out-of-range depths are clamped into the supported range.
  localparam int N_STAGES = (STAGES < 1) ? 1 :
                            ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES);
  // Stage word layout: {err, overflow, zero, carry, alu}.
  localparam int WORD_W   = WIDTH + 4;

  logic [WIDTH-1:0]  core_alu_s;
  logic              core_carry_s;
  logic              core_zero_s;
  logic              core_ovf_s;
  logic              core_err_s;
  logic [WORD_W-1:0] core_word_s;

  logic [N_STAGES-1:0] valid_r;
  logic [N_STAGES-1:0] load_s;
  logic [N_STAGES-1:0] in_valid_s;
  logic [WORD_W-1:0]   word_r    [N_STAGES];
  logic [WORD_W-1:0]   in_word_s [N_STAGES];

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (bus.a),
    .b        (bus.b),
    .cin      (bus.cin),
    .ctl      (bus.ctl),
    .alu      (core_alu_s),
    .carry    (core_carry_s),
    .zero     (core_zero_s),
    .overflow (core_ovf_s),
    .err      (core_err_s)
  );

  assign core_word_s = {core_err_s, core_ovf_s, core_zero_s, core_carry_s, core_alu_s};

  // A stage can load whenever the consumer takes the last result or any stage
  // at or after it is empty; that chain of emptiness is what lets bubbles
  // collapse. Incoming bubbles carry an all-zero word so idle outputs stay 0.
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    assign load_s[k] = bus.ready_out | ~(&valid_r[N_STAGES-1:k]);
    if (k == 0) begin : g_first
      assign in_valid_s[k] = bus.valid_in;
      assign in_word_s[k]  = bus.valid_in ? core_word_s : {WORD_W{1'b0}};
    end else begin : g_next
      assign in_valid_s[k] = valid_r[k-1];
      assign in_word_s[k]  = word_r[k-1];
    end
  end

  // Stage registers: clear on reset, otherwise advance each stage that loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {N_STAGES{1'b0}};
      for (int k = 0; k < N_STAGES; k++) begin
        word_r[k] <= {WORD_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        if (load_s[k]) begin
          valid_r[k] <= in_valid_s[k];
          word_r[k]  <= in_word_s[k];
        end else begin
          valid_r[k] <= valid_r[k];
          word_r[k]  <= word_r[k];
        end
      end
    end
  end

  assign bus.ready_in  = load_s[0];
  assign bus.valid_out = valid_r[N_STAGES-1];
  assign {bus.err, bus.overflow, bus.zero, bus.carry, bus.alu} = word_r[N_STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a WIDTH=4/STAGES=2 instance and a
// WIDTH=8/STAGES=1 instance, each scored against an arithmetic reference.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic        err;
    logic        ovf;
    logic        zero;
    logic        carry;
    logic [31:0] alu;
  } res_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nchecks = 0;
  int   nerrors = 0;

  res_t q4[$];
  res_t q8[$];

  alu_pipe_if #(.WIDTH(4)) b4 ();
  alu_pipe_if #(.WIDTH(8)) b8 ();

  alu_pipe #(.WIDTH(4), .STAGES(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  alu_pipe #(.WIDTH(8), .STAGES(1)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t alu_ref(input int w, input longint a, input longint b,
                                   input longint cin, input int ctl);
    longint full, m, half, sa, sb, r, sr;
    res_t   o;
    full = longint'(1) << w;
    m    = full - 1;
    half = full / 2;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    o    = '0;
    r    = 0;
    sr   = 0;
    case (ctl)
      0:  r = a;
      1:  begin r = a + 1;       o.carry = (r > m);  sr = sa + 1;        end
      2:  begin r = a - 1;       o.carry = (a == 0); sr = sa - 1;        end
      3:  begin r = a + b;       o.carry = (r > m);  sr = sa + sb;       end
      4:  begin r = a + b + cin; o.carry = (r > m);  sr = sa + sb + cin; end
      5:  begin r = a - b;       o.carry = (r < 0);  sr = sa - sb;       end
      6:  begin r = a - b - cin; o.carry = (r < 0);  sr = sa - sb - cin; end
      7:  r = a & b;
      8:  r = a | b;
      9:  r = a ^ b;
      10: begin r = a * 2;                        o.carry = (a >= half); end
      11: begin r = a / 2;                        o.carry = (a % 2 == 1); end
      12: begin r = a * 2 + ((a >= half) ? 1 : 0); o.carry = (a >= half); end
      13: begin r = a / 2 + (a % 2) * half;       o.carry = (a % 2 == 1); end
      default: o.err = (ctl >= int'(OP_ILLEGAL_MIN));
    endcase
    o.ovf  = (sr < -half) || (sr > half - 1);
    o.alu  = 32'(r & m);
    o.zero = (o.alu == 32'd0);
    return o;
  endfunction

  // Scoreboard for the 4-bit pipe: every cycle with valid_out must show the
  // oldest outstanding expected result, stalled or not.
  always @(negedge clk) begin
    if (reset) begin
      q4.delete();
    end else begin
      if (b4.valid_out) begin
        if (q4.size() == 0) begin
          check("p4_unexpected_valid", 64'(b4.valid_out), 64'(0));
        end else begin
          check("p4_result", 64'(res_t'{b4.err, b4.overflow, b4.zero, b4.carry, 32'(b4.alu)}),
                64'(q4[0]));
          if (b4.ready_out) void'(q4.pop_front());
        end
      end
      if (b4.valid_in && b4.ready_in)
        q4.push_back(alu_ref(4, longint'(b4.a), longint'(b4.b), longint'(b4.cin), int'(b4.ctl)));
    end
  end

  // Scoreboard for the 8-bit single-stage pipe.
  always @(negedge clk) begin
    if (reset) begin
      q8.delete();
    end else begin
      if (b8.valid_out) begin
        if (q8.size() == 0) begin
          check("p8_unexpected_valid", 64'(b8.valid_out), 64'(0));
        end else begin
          check("p8_result", 64'(res_t'{b8.err, b8.overflow, b8.zero, b8.carry, 32'(b8.alu)}),
                64'(q8[0]));
          if (b8.ready_out) void'(q8.pop_front());
        end
      end
      if (b8.valid_in && b8.ready_in)
        q8.push_back(alu_ref(8, longint'(b8.a), longint'(b8.b), longint'(b8.cin), int'(b8.ctl)));
    end
  end

  task automatic issue4(input logic [3:0] op_a, input logic [3:0] op_b, input logic op_c,
                        input logic [3:0] op_ctl);
    int w = 0;
    b4.valid_in = 1'b1; b4.a = op_a; b4.b = op_b; b4.cin = op_c; b4.ctl = op_ctl;
    @(negedge clk);
    while (!b4.ready_in && w < 50) begin w++; @(negedge clk); end
    if (w >= 50) check("issue4_timeout", 64'(b4.ready_in), 64'(1));
    @(posedge clk); #1;
    b4.valid_in = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c,
                        input logic [3:0] op_ctl);
    int w = 0;
    b8.valid_in = 1'b1; b8.a = op_a; b8.b = op_b; b8.cin = op_c; b8.ctl = op_ctl;
    @(negedge clk);
    while (!b8.ready_in && w < 50) begin w++; @(negedge clk); end
    if (w >= 50) check("issue8_timeout", 64'(b8.ready_in), 64'(1));
    @(posedge clk); #1;
    b8.valid_in = 1'b0;
  endtask

  // One transaction on the 4-bit pipe with latency and field checks.
  task automatic run4(input string tag, input logic [3:0] op_a, input logic [3:0] op_b,
                      input logic op_c, input logic [3:0] op_ctl, input logic [3:0] e_alu,
                      input logic e_c, input logic e_z, input logic e_o, input logic e_e);
    int lat = 0;
    b4.ready_out = 1'b1;
    issue4(op_a, op_b, op_c, op_ctl);
    do begin @(negedge clk); lat++; end while (!b4.valid_out && lat < 20);
    check({tag, "_latency"}, 64'(lat), 64'(2));
    check({tag, "_alu"},   64'(b4.alu),      64'(e_alu));
    check({tag, "_carry"}, 64'(b4.carry),    64'(e_c));
    check({tag, "_zero"},  64'(b4.zero),     64'(e_z));
    check({tag, "_ovf"},   64'(b4.overflow), 64'(e_o));
    check({tag, "_err"},   64'(b4.err),      64'(e_e));
    @(posedge clk); #1;
  endtask

  task automatic rand4(input int n, input int rdy_pct);
    int   acc = 0;
    int   guard = 0;
    logic pend = 1'b0;
    logic hit;
    while (acc < n && guard < 20000) begin
      guard++;
      if (!pend && $urandom_range(0, 3) != 0) begin
        b4.valid_in = 1'b1; b4.a = 4'($urandom); b4.b = 4'($urandom);
        b4.cin = 1'($urandom); b4.ctl = 4'($urandom); pend = 1'b1;
      end
      b4.ready_out = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      hit = b4.valid_in && b4.ready_in;
      @(posedge clk); #1;
      if (hit) begin acc++; pend = 1'b0; b4.valid_in = 1'b0; end
    end
    check("rand4_accepted", 64'(acc), 64'(n));
  endtask

  task automatic rand8(input int n, input int rdy_pct);
    int   acc = 0;
    int   guard = 0;
    logic pend = 1'b0;
    logic hit;
    while (acc < n && guard < 20000) begin
      guard++;
      if (!pend && $urandom_range(0, 3) != 0) begin
        b8.valid_in = 1'b1; b8.a = 8'($urandom); b8.b = 8'($urandom);
        b8.cin = 1'($urandom); b8.ctl = 4'($urandom); pend = 1'b1;
      end
      b8.ready_out = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      hit = b8.valid_in && b8.ready_in;
      @(posedge clk); #1;
      if (hit) begin acc++; pend = 1'b0; b8.valid_in = 1'b0; end
    end
    check("rand8_accepted", 64'(acc), 64'(n));
  endtask

  task automatic drain(input string tag);
    b4.ready_out = 1'b1; b8.ready_out = 1'b1;
    for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    check({tag, "_q4_empty"}, 64'(q4.size()), 64'(0));
    check({tag, "_q8_empty"}, 64'(q8.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    int   lat;
    logic hit;

    b4.valid_in = 1'b0; b4.a = 4'd0; b4.b = 4'd0; b4.cin = 1'b0; b4.ctl = 4'd0; b4.ready_out = 1'b1;
    b8.valid_in = 1'b0; b8.a = 8'd0; b8.b = 8'd0; b8.cin = 1'b0; b8.ctl = 4'd0; b8.ready_out = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid_out", 64'(b4.valid_out), 64'(0));
    check("rst_alu",       64'(b4.alu),       64'(0));
    check("rst_flags",     64'({b4.carry, b4.zero, b4.overflow, b4.err}), 64'(0));
    check("rst_ready_in",  64'(b4.ready_in),  64'(1));
    check("rst8_valid_out", 64'(b8.valid_out), 64'(0));
    check("rst8_ready_in",  64'(b8.ready_in),  64'(1));
    @(posedge clk); #1;

    // Directed vectors on the 4-bit, two-stage pipe
    run4("add",     4'b0111, 4'b0001, 1'b0, 4'd3,  4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    run4("sub_b",   4'b0000, 4'b0000, 1'b1, 4'd6,  4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    run4("rot_r",   4'b0001, 4'b0000, 1'b0, 4'd13, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    run4("shift_l", 4'b1000, 4'b0000, 1'b0, 4'd10, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run4("illegal", 4'b1010, 4'b0101, 1'b1, 4'd15, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run4("legal",   4'b0011, 4'b0000, 1'b0, 4'd0,  4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    run4("dec0",    4'b0000, 4'b0000, 1'b0, 4'd2,  4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    run4("sub_ovf", 4'b1000, 4'b0001, 1'b0, 4'd5,  4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure: four INCs while the consumer stalls, then release
    b4.ready_out = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (idx < 4) begin
        b4.valid_in = 1'b1; b4.a = 4'(idx); b4.b = 4'd0; b4.cin = 1'b0; b4.ctl = 4'd1;
      end else begin
        b4.valid_in = 1'b0;
      end
      @(negedge clk);
      if (cyc == 6) begin
        check("bp_ready_in_low", 64'(b4.ready_in), 64'(0));
        check("bp_accepted",     64'(idx),         64'(2));
      end
      hit = b4.valid_in && b4.ready_in;
      @(posedge clk); #1;
      if (hit) idx++;
      if (cyc == 6) b4.ready_out = 1'b1;
    end
    check("bp_all_accepted", 64'(idx), 64'(4));
    drain("bp");

    // Reset with both stages full; nothing stale may follow
    b4.ready_out = 1'b0;
    issue4(4'd5, 4'd0, 1'b0, 4'd1);
    issue4(4'd6, 4'd0, 1'b0, 4'd1);
    @(negedge clk);
    check("full_ready_in", 64'(b4.ready_in),  64'(0));
    check("full_valid",    64'(b4.valid_out), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    b4.valid_in = 1'b1; b4.a = 4'd9; b4.ctl = 4'd3;
    @(posedge clk); #1;
    reset = 1'b0;
    b4.valid_in = 1'b0;
    @(negedge clk);
    check("mid_rst_valid_out", 64'(b4.valid_out), 64'(0));
    check("mid_rst_outputs",
          64'({b4.alu, b4.carry, b4.zero, b4.overflow, b4.err}), 64'(0));
    check("mid_rst_ready_in",  64'(b4.ready_in),  64'(1));
    b4.ready_out = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_stale", 64'(b4.valid_out), 64'(0));
    end
    @(posedge clk); #1;

    // 8-bit single-stage pipe: ADD_c wrap with one-cycle latency
    b8.ready_out = 1'b1;
    issue8(8'hFF, 8'h00, 1'b1, 4'd4);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b8.valid_out && lat < 20);
    check("p8_addc_latency", 64'(lat),          64'(1));
    check("p8_addc_alu",     64'(b8.alu),       64'(8'h00));
    check("p8_addc_carry",   64'(b8.carry),     64'(1));
    check("p8_addc_zero",    64'(b8.zero),      64'(1));
    check("p8_addc_ovf",     64'(b8.overflow),  64'(0));
    @(posedge clk); #1;

    // Randomized traffic against the reference, light and heavy stalling
    rand4(200, 75);
    drain("r4a");
    rand4(100, 25);
    drain("r4b");
    rand8(150, 70);
    drain("r8a");
    rand8(80, 20);
    drain("r8b");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
